// File: rtl/mem_byte_bridge_pkg.sv
// mem_byte_bridge_pkg: shared types and helpers for the word-to-byte memory bridge
package mem_byte_bridge_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} bridge_state_t;
  typedef logic [1:0] lane_t;
  typedef logic [3:0] lane_mask_t;
  function automatic logic [31:0] lane_bits(lane_mask_t m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction
endpackage

// File: rtl/mem_byte_bridge_picker.sv
// byte_lane_picker: lowest set lane of a lane mask plus an any-lane-left flag
module byte_lane_picker
  import mem_byte_bridge_pkg::*;
(
  input  lane_mask_t mask,
  output lane_t      lane,
  output logic       any
);
  // priority pick from lane 0 upward
  always_comb begin
    lane = mask[0] ? 2'd0 : mask[1] ? 2'd1 : mask[2] ? 2'd2 : 2'd3;
    any = |mask;
  end
endmodule

// File: rtl/mem_byte_bridge.sv
// mem_byte_bridge: splits 32-bit core memory requests into byte accesses on an 8-bit bus
module mem_byte_bridge
  import mem_byte_bridge_pkg::*;
#(
  parameter bit READ_ALL_LANES = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  output logic        mem_resp,
  output logic [31:0] mem_rdata,
  output logic        byte_read,
  output logic        byte_write,
  output logic [31:0] byte_address,
  output logic [7:0]  byte_wdata,
  input  logic [7:0]  byte_rdata,
  input  logic        byte_resp
);
  bridge_state_t state;
  logic          op_write;
  logic [29:0]   word_addr;
  logic [31:0]   wdata;
  lane_mask_t    mask;
  lane_mask_t    init_mask;
  lane_mask_t    rest_mask;
  lane_mask_t    pick_mask;
  lane_t         lane;
  lane_t         pick_lane;
  logic          pick_any;
  logic          unused_addr_lsb;
  assign unused_addr_lsb = ^mem_address[1:0];
  assign init_mask = (mem_write || !READ_ALL_LANES) ? mem_byte_enable : 4'hF;
  assign rest_mask = mask & ~(4'b0001 << lane);
  assign pick_mask = (state == IDLE) ? init_mask : rest_mask;
  assign byte_address = {word_addr, lane};
  assign byte_wdata = wdata[8*lane +: 8];
  byte_lane_picker u_picker (
    .mask(pick_mask),
    .lane(pick_lane),
    .any (pick_any)
  );
  // request capture, lane walk and one-cycle completion pulse
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      op_write <= 1'b0;
      word_addr <= '0;
      wdata <= '0;
      mask <= '0;
      lane <= '0;
      byte_read <= 1'b0;
      byte_write <= 1'b0;
      mem_resp <= 1'b0;
      mem_rdata <= '0;
    end else begin
      case (state)
        IDLE: if (mem_read || mem_write) begin
          op_write <= mem_write;
          word_addr <= mem_address[31:2];
          wdata <= mem_wdata;
          mask <= init_mask;
          lane <= pick_lane;
          if (!mem_write) mem_rdata <= mem_rdata & lane_bits(init_mask);
          byte_write <= pick_any & mem_write;
          byte_read <= pick_any & !mem_write;
          mem_resp <= !pick_any;
          state <= pick_any ? ACCESS : DONE;
        end
        ACCESS: if (byte_resp) begin
          if (!op_write) mem_rdata[8*lane +: 8] <= byte_rdata;
          mask <= rest_mask;
          lane <= pick_lane;
          byte_write <= pick_any & op_write;
          byte_read <= pick_any & !op_write;
          mem_resp <= !pick_any;
          state <= pick_any ? ACCESS : DONE;
        end
        default: begin
          mem_resp <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
endmodule
